// File: rtl/memory_bank_demand_allocator_pkg.sv
// memory_bank_demand_allocator_pkg: shared FSM encodings and width helper for bank allocators
package memory_bank_demand_allocator_pkg;
   typedef enum logic [1:0] {ENABLE = 2'b01, DRAIN = 2'b10, CHANGE = 2'b11} state_t;
   function automatic int clogb(input int n);
      int w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction
endpackage

// File: rtl/memory_bank_demand_allocator_rr_next_port_select.sv
// memory_bank_demand_allocator_rr_next_port_select: round-robin search for the next demanding port after the owner
module memory_bank_demand_allocator_rr_next_port_select
   import memory_bank_demand_allocator_pkg::*;
#(
   parameter int num_ports = 5
) (
   input  logic [clogb(num_ports)-1:0] owner,
   input  logic [num_ports-1:0]        demand,
   output logic [clogb(num_ports)-1:0] next,
   output logic                        found
);
   localparam int ow = clogb(num_ports);
   always_comb begin
      next = ow'((int'(owner) + 1) % num_ports);
      found = 1'b0;
      for (int i = num_ports - 1; i >= 1; i--) begin
         if (demand[(int'(owner) + i) % num_ports]) begin
            next = ow'((int'(owner) + i) % num_ports);
            found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/memory_bank_demand_allocator.sv
// memory_bank_demand_allocator: hands a shared VC bank to one port at a time, moving it on idle plus demand
module memory_bank_demand_allocator
   import memory_bank_demand_allocator_pkg::*;
#(
   parameter int num_ports        = 5,
   parameter int num_vcs_per_bank = 2,
   parameter int threshold        = 4,
   parameter int reset_owner      = 0,
   parameter bit rotate_always    = 1'b0
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [num_ports-1:0]                  port_demand,
   input  logic [num_vcs_per_bank-1:0]           shared_ivc_empty,
   input  logic [num_ports*num_vcs_per_bank-1:0] shared_vc_allocated,
   output logic [num_ports-1:0]                  memory_bank_grant_out,
   output logic [clogb(num_ports)-1:0]           owner_id,
   output logic                                  ready_for_allocation,
   output logic                                  handoff
);
   localparam int ow = clogb(num_ports);
   localparam int cw = clogb(threshold + 1);
   state_t state, state_n;
   logic [cw-1:0] cnt, cnt_n;
   logic [ow-1:0] owner_n, next;
   logic handoff_n, found, idle, go, cnt_full;
   assign idle = &shared_ivc_empty & ~|shared_vc_allocated;
   assign go = |(port_demand & ~memory_bank_grant_out) | rotate_always;
   assign cnt_full = int'(cnt) >= threshold;
   memory_bank_demand_allocator_rr_next_port_select #(.num_ports(num_ports)) rr (
      .owner(owner_id),
      .demand(port_demand),
      .next(next),
      .found(found)
   );
   always_comb begin
      state_n = state;
      owner_n = owner_id;
      cnt_n = '0;
      handoff_n = 1'b0;
      case (state)
         ENABLE: begin
            cnt_n = !idle ? '0 : (cnt_full ? cnt : cnt + 1'b1);
            state_n = (idle && cnt_full && go) ? DRAIN : ENABLE;
         end
         DRAIN: state_n = !go ? ENABLE : (idle ? CHANGE : DRAIN);
         CHANGE: begin
            state_n = ENABLE;
            // without legacy rotation, a vanished demand leaves the owner in place
            owner_n = (found || rotate_always) ? next : owner_id;
            handoff_n = found || rotate_always;
         end
         default: begin
            state_n = ENABLE;
            owner_n = ow'(reset_owner);
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ENABLE;
         cnt <= '0;
         owner_id <= ow'(reset_owner);
         memory_bank_grant_out <= num_ports'(1) << reset_owner;
         ready_for_allocation <= 1'b1;
         handoff <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         owner_id <= owner_n;
         memory_bank_grant_out <= num_ports'(1) << owner_n;
         ready_for_allocation <= state_n == ENABLE;
         handoff <= handoff_n;
      end
   end
endmodule
